// File: rtl/cell_row_pkg.sv
// Shared constants, state encoding and a lane-read helper for the cell row writer.
// Used by cell_row_writer and row_lane_replace.
package cell_row_pkg;

   localparam int CELLS  = 16;
   localparam int CELL_W = 2;
   localparam int SEL_W  = 4;
   localparam int ROW_W  = CELLS * CELL_W;
   localparam int CNT_W  = SEL_W + 1;

   localparam logic [CELL_W-1:0] CELL_EMPTY = '0;
   localparam logic [SEL_W-1:0]  LAST_IDX   = SEL_W'(CELLS - 1);
   localparam logic [SEL_W-1:0]  IDX_ONE    = SEL_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   // Same lane mapping as the 16-to-1 selector: cell i lives at bits [2i+1:2i].
   function automatic logic [CELL_W-1:0] cell_of(input logic [ROW_W-1:0] r,
                                                 input logic [SEL_W-1:0] idx);
      return r[idx*CELL_W +: CELL_W];
   endfunction

endpackage

// File: rtl/row_lane_replace.sv
// Combinational inverse of the lane selector: returns the row with one lane overwritten.
// Shared by the write path and the clear sweep.
module row_lane_replace #(
   parameter int CELLS  = 16,
   parameter int CELL_W = 2,
   parameter int SEL_W  = 4
) (
   input  logic [CELLS*CELL_W-1:0] row_in,
   input  logic [SEL_W-1:0]        index,
   input  logic [CELL_W-1:0]       data,
   output logic [CELLS*CELL_W-1:0] row_out
);

   always_comb begin
      row_out = row_in;
      row_out[index*CELL_W +: CELL_W] = data;
   end

endmodule

// File: rtl/cell_row_writer.sv
// Row register of 16 two-bit cells with handshaked single-cell writes and a 16-cycle clear sweep.
// Optional macro CELL_ROW_PROTECT_EN rejects non-zero writes to occupied cells (wr_err pulse).
module cell_row_writer
   import cell_row_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [SEL_W-1:0]  wr_select,
   input  logic [CELL_W-1:0] wr_data,
   input  logic              clr_req,
   output logic [ROW_W-1:0]  row,
   output logic              busy,
   output logic              wr_ack,
   output logic              wr_err,
   output logic [CNT_W-1:0]  count
);

   state_t            state;
   state_t            state_next;
   logic [SEL_W-1:0]  clr_idx;
   logic [SEL_W-1:0]  lane_idx;
   logic [CELL_W-1:0] lane_data;
   logic [CELL_W-1:0] old_cell;
   logic [ROW_W-1:0]  row_repl;
   logic              accept;
   logic              reject;
   logic              commit;
   logic              row_we;
   logic [CNT_W-1:0]  count_next;

   // A pending clear request blocks the handshake so the sweep always wins.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      wr_ready   = 1'b0;
      case (state)
         IDLE: begin
            wr_ready = !clr_req;
            if (clr_req) state_next = CLEAR;
         end
         CLEAR: begin
            busy = 1'b1;
            if (clr_idx == LAST_IDX) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign accept    = wr_valid && wr_ready;
   assign lane_idx  = busy ? clr_idx : wr_select;
   assign lane_data = busy ? CELL_EMPTY : wr_data;
   assign old_cell  = cell_of(row, lane_idx);

`ifdef CELL_ROW_PROTECT_EN
   assign reject = (wr_data != CELL_EMPTY) && (old_cell != CELL_EMPTY);
`else
   assign reject = 1'b0;
`endif

   assign commit = accept && !reject;
   assign row_we = busy || commit;

   row_lane_replace #(
      .CELLS  (CELLS),
      .CELL_W (CELL_W),
      .SEL_W  (SEL_W)
   ) u_replace (
      .row_in  (row),
      .index   (lane_idx),
      .data    (lane_data),
      .row_out (row_repl)
   );

   // Occupancy only moves when a lane crosses between empty and non-empty.
   always_comb begin
      count_next = count;
      if (busy) begin
         if (old_cell != CELL_EMPTY) count_next = count - CNT_ONE;
      end else if (commit) begin
         if (old_cell == CELL_EMPTY && lane_data != CELL_EMPTY)
            count_next = count + CNT_ONE;
         else if (old_cell != CELL_EMPTY && lane_data == CELL_EMPTY)
            count_next = count - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         row     <= '0;
         count   <= '0;
         clr_idx <= '0;
         wr_ack  <= 1'b0;
      end else begin
         state   <= state_next;
         if (row_we) row <= row_repl;
         count   <= count_next;
         clr_idx <= busy ? clr_idx + IDX_ONE : '0;
         wr_ack  <= commit;
      end
   end

`ifdef CELL_ROW_PROTECT_EN
   always_ff @(posedge clk) begin
      if (reset) wr_err <= 1'b0;
      else       wr_err <= accept && reject;
   end
`else
   assign wr_err = 1'b0;
`endif

endmodule

// File: tb/tb_cell_row_writer.sv
// Self-checking bench for cell_row_writer: directed scenarios plus randomized traffic
// compared against a cell-array model of the row.
module tb_cell_row_writer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic [3:0]  wr_select = '0;
   logic [1:0]  wr_data = '0;
   logic        clr_req = 1'b0;
   logic [31:0] row;
   logic        busy;
   logic        wr_ack;
   logic        wr_err;
   logic [4:0]  count;

   int n_checks = 0;
   int n_fails  = 0;

   logic [1:0] mcells [16];
   int         sweep_left = 0;
   int         sweep_pos  = 0;

`ifdef CELL_ROW_PROTECT_EN
   localparam bit PROTECT = 1'b1;
`else
   localparam bit PROTECT = 1'b0;
`endif

   cell_row_writer dut (
      .clk       (clk),
      .reset     (reset),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_select (wr_select),
      .wr_data   (wr_data),
      .clr_req   (clr_req),
      .row       (row),
      .busy      (busy),
      .wr_ack    (wr_ack),
      .wr_err    (wr_err),
      .count     (count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] model_row();
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) r[i*2 +: 2] = mcells[i];
      return r;
   endfunction

   function automatic logic [4:0] model_count();
      int n;
      n = 0;
      for (int i = 0; i < 16; i++) if (mcells[i] != 2'b00) n++;
      return 5'(n);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < 16; i++) mcells[i] = 2'b00;
      sweep_left = 0;
      sweep_pos  = 0;
   endtask

   // Drive one accepted write for a single edge; caller checks the response.
   task automatic drive_write(input logic [3:0] s, input logic [1:0] d);
      wr_valid  = 1'b1;
      wr_select = s;
      wr_data   = d;
      step();
      wr_valid  = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      clear_model();
      n_checks++; if (row !== 32'h0)  begin n_fails++; $display("[TB] FAIL reset_row got %h want 0", row); end
      n_checks++; if (count !== 5'd0) begin n_fails++; $display("[TB] FAIL reset_count got %0d want 0", count); end
      n_checks++; if (busy !== 1'b0)  begin n_fails++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (wr_ack !== 1'b0 || wr_err !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_pulses got ack=%b err=%b want 0/0", wr_ack, wr_err); end
      n_checks++; if (wr_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_ready got %b want 1", wr_ready); end
   endtask

   task automatic test_single_write();
      drive_write(4'd5, 2'b10);
      mcells[5] = 2'b10;
      n_checks++; if (row !== 32'h0000_0800) begin n_fails++; $display("[TB] FAIL single_row got %h want 00000800", row); end
      n_checks++; if (count !== 5'd1) begin n_fails++; $display("[TB] FAIL single_count got %0d want 1", count); end
      n_checks++; if (wr_ack !== 1'b1) begin n_fails++; $display("[TB] FAIL single_ack got %b want 1", wr_ack); end
      step();
      n_checks++; if (wr_ack !== 1'b0) begin n_fails++; $display("[TB] FAIL single_ack_drop got %b want 0", wr_ack); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] sels [3];
      logic [1:0] dats [3];
      sels = '{4'd0, 4'd15, 4'd7};
      dats = '{2'b01, 2'b11, 2'b10};
      test_reset();
      wr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wr_select = sels[i];
         wr_data   = dats[i];
         step();
         mcells[sels[i]] = dats[i];
         n_checks++; if (wr_ack !== 1'b1) begin n_fails++; $display("[TB] FAIL b2b_ack%0d got %b want 1", i, wr_ack); end
         n_checks++; if (row !== model_row()) begin n_fails++; $display("[TB] FAIL b2b_row%0d got %h want %h", i, row, model_row()); end
      end
      wr_valid = 1'b0;
      n_checks++; if (row !== 32'hC000_8001) begin n_fails++; $display("[TB] FAIL b2b_final_row got %h want C0008001", row); end
      n_checks++; if (count !== 5'd3) begin n_fails++; $display("[TB] FAIL b2b_count got %0d want 3", count); end
      step();
      n_checks++; if (wr_ack !== 1'b0) begin n_fails++; $display("[TB] FAIL b2b_ack_drop got %b want 0", wr_ack); end
   endtask

   // Expects the row left by test_back_to_back; writes during the sweep must be ignored.
   task automatic test_clear_sweep();
      clr_req = 1'b1;
      #1;
      n_checks++; if (wr_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL sweep_req_ready got %b want 0", wr_ready); end
      step();
      clr_req = 1'b0;
      for (int k = 0; k < 16; k++) begin
         wr_valid  = 1'b1;
         wr_select = 4'($urandom_range(0, 15));
         wr_data   = 2'($urandom_range(1, 3));
         #1;
         n_checks++; if (busy !== 1'b1) begin n_fails++; $display("[TB] FAIL sweep_busy%0d got %b want 1", k, busy); end
         n_checks++; if (wr_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL sweep_ready%0d got %b want 0", k, wr_ready); end
         n_checks++; if (count !== model_count()) begin n_fails++; $display("[TB] FAIL sweep_count%0d got %0d want %0d", k, count, model_count()); end
         n_checks++; if (wr_ack !== 1'b0) begin n_fails++; $display("[TB] FAIL sweep_ack%0d got %b want 0", k, wr_ack); end
         step();
         mcells[k] = 2'b00;
      end
      wr_valid = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL sweep_end_busy got %b want 0", busy); end
      n_checks++; if (row !== 32'h0) begin n_fails++; $display("[TB] FAIL sweep_end_row got %h want 0", row); end
      n_checks++; if (count !== 5'd0) begin n_fails++; $display("[TB] FAIL sweep_end_count got %0d want 0", count); end
   endtask

   task automatic test_clear_vs_write();
      bit saw_ack;
      saw_ack = 1'b0;
      drive_write(4'd9, 2'b01);
      step();
      clr_req   = 1'b1;
      wr_valid  = 1'b1;
      wr_select = 4'd3;
      wr_data   = 2'b01;
      #1;
      n_checks++; if (wr_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL cvw_ready got %b want 0", wr_ready); end
      step();
      clr_req  = 1'b0;
      wr_valid = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_fails++; $display("[TB] FAIL cvw_busy got %b want 1", busy); end
      for (int i = 0; i < 20 && busy === 1'b1; i++) begin
         if (wr_ack === 1'b1) saw_ack = 1'b1;
         step();
      end
      if (wr_ack === 1'b1) saw_ack = 1'b1;
      n_checks++; if (busy !== 1'b0) begin n_fails++; $display("[TB] FAIL cvw_timeout busy got %b want 0", busy); end
      n_checks++; if (saw_ack !== 1'b0) begin n_fails++; $display("[TB] FAIL cvw_ack got %b want 0", saw_ack); end
      n_checks++; if (row !== 32'h0 || count !== 5'd0) begin n_fails++; $display("[TB] FAIL cvw_final got row=%h count=%0d want 0/0", row, count); end
      clear_model();
   endtask

   task automatic test_reset_mid_sweep();
      drive_write(4'd15, 2'b11);
      drive_write(4'd2, 2'b01);
      clr_req = 1'b1;
      step();
      clr_req = 1'b0;
      for (int i = 0; i < 8; i++) step();
      n_checks++; if (row !== 32'hC000_0000 || count !== 5'd1) begin n_fails++; $display("[TB] FAIL mid_sweep_state got row=%h count=%0d want C0000000/1", row, count); end
      reset     = 1'b1;
      wr_valid  = 1'b1;
      wr_select = 4'd4;
      wr_data   = 2'b11;
      step();
      n_checks++; if (row !== 32'h0 || count !== 5'd0 || busy !== 1'b0) begin n_fails++; $display("[TB] FAIL mid_reset got row=%h count=%0d busy=%b want 0/0/0", row, count, busy); end
      n_checks++; if (wr_ack !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_write_ack got %b want 0", wr_ack); end
      reset    = 1'b0;
      wr_valid = 1'b0;
      step();
      n_checks++; if (row !== 32'h0 || busy !== 1'b0) begin n_fails++; $display("[TB] FAIL post_reset got row=%h busy=%b want 0/0", row, busy); end
      clear_model();
   endtask

   task automatic test_protect();
      drive_write(4'd3, 2'b01);
      mcells[3] = 2'b01;
      n_checks++; if (wr_ack !== 1'b1 || row !== 32'h0000_0040) begin n_fails++; $display("[TB] FAIL prot_setup got ack=%b row=%h want 1/00000040", wr_ack, row); end
      drive_write(4'd3, 2'b10);
      if (!PROTECT) mcells[3] = 2'b10;
      n_checks++; if (wr_ack !== !PROTECT || wr_err !== PROTECT) begin n_fails++; $display("[TB] FAIL prot_overwrite got ack=%b err=%b want %b/%b", wr_ack, wr_err, !PROTECT, PROTECT); end
      n_checks++; if (row !== model_row() || count !== 5'd1) begin n_fails++; $display("[TB] FAIL prot_row got %h/%0d want %h/1", row, count, model_row()); end
      drive_write(4'd3, 2'b00);
      mcells[3] = 2'b00;
      n_checks++; if (wr_ack !== 1'b1 || wr_err !== 1'b0) begin n_fails++; $display("[TB] FAIL prot_erase got ack=%b err=%b want 1/0", wr_ack, wr_err); end
      n_checks++; if (row !== 32'h0 || count !== 5'd0) begin n_fails++; $display("[TB] FAIL prot_erase_row got %h/%0d want 0/0", row, count); end
      step();
   endtask

   // Random writes and occasional clear requests against the cell-array model.
   task automatic test_random();
      logic       v, c, exp_ack, exp_err;
      logic [3:0] s;
      logic [1:0] d;
      for (int n = 0; n < 300; n++) begin
         v = 1'($urandom_range(0, 1));
         c = ($urandom_range(0, 24) == 0);
         s = 4'($urandom_range(0, 15));
         d = 2'($urandom_range(0, 3));
         wr_valid = v; clr_req = c; wr_select = s; wr_data = d;
         #1;
         n_checks++; if (wr_ready !== (sweep_left == 0 && !c)) begin n_fails++; $display("[TB] FAIL rnd_ready%0d got %b want %b", n, wr_ready, (sweep_left == 0 && !c)); end
         exp_ack = 1'b0;
         exp_err = 1'b0;
         if (sweep_left > 0) begin
            mcells[sweep_pos] = 2'b00;
            sweep_pos++;
            sweep_left--;
         end else if (c) begin
            sweep_left = 16;
            sweep_pos  = 0;
         end else if (v) begin
            if (PROTECT && d != 2'b00 && mcells[s] != 2'b00) exp_err = 1'b1;
            else begin
               mcells[s] = d;
               exp_ack   = 1'b1;
            end
         end
         step();
         n_checks++; if (row !== model_row()) begin n_fails++; $display("[TB] FAIL rnd_row%0d got %h want %h", n, row, model_row()); end
         n_checks++; if (count !== model_count()) begin n_fails++; $display("[TB] FAIL rnd_count%0d got %0d want %0d", n, count, model_count()); end
         n_checks++; if (busy !== (sweep_left > 0)) begin n_fails++; $display("[TB] FAIL rnd_busy%0d got %b want %b", n, busy, (sweep_left > 0)); end
         n_checks++; if (wr_ack !== exp_ack || wr_err !== exp_err) begin n_fails++; $display("[TB] FAIL rnd_resp%0d got ack=%b err=%b want %b/%b", n, wr_ack, wr_err, exp_ack, exp_err); end
      end
      wr_valid = 1'b0;
      clr_req  = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_clear_sweep();
      test_clear_vs_write();
      test_reset_mid_sweep();
      test_protect();
      test_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
